// File: rtl/nf10_upb_reset_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
// Optional lock-loss counter is enabled with NF10_UPB_RESET_SEQ_LOSS_CNT_EN.
package nf10_upb_reset_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } seq_state_e;

  localparam int unsigned LOSS_CNT_W = 8;

  // The shared counter times both the lock-stable interval and the per-stage delay.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/nf10_upb_sync_2ff.sv
// Two-flop synchronizer for asynchronous level signals into the clk domain.
module nf10_upb_sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: reset is sampled on the clock edge (synchronous), so it is a plain
  // if-branch inside always_ff @(posedge clk) with no reset in the sensitivity list.
  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values;
  // blocking here would collapse the two stages into one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/nf10_upb_reset_sequencer.sv
// Staged reset release after qualified lock-stable interval; re-asserts on lock loss.
// Optional lock-loss event counter: define NF10_UPB_RESET_SEQ_LOSS_CNT_EN.
module nf10_upb_reset_sequencer
  import nf10_upb_reset_seq_pkg::*;
#(
  parameter int unsigned N_STAGES            = 3,
  parameter int unsigned STABLE_CYCLES       = 1024,
  parameter int unsigned STAGE_DELAY         = 16,
  parameter int unsigned USE_DCI             = 1,
  parameter int unsigned USE_IODELAY_CONTROL = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked_in,
  input  logic                  dci_locked_in,
  input  logic                  iodelay_rdy_in,
  output logic [N_STAGES-1:0]   stage_reset_n_out,
  output logic                  ready_out,
  output logic [LOSS_CNT_W-1:0] lock_loss_count_out
);

  localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES, STAGE_DELAY);
  localparam int unsigned IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_STAGES - 1);

  logic [2:0] lock_raw;
  logic [2:0] lock_s;
  logic       locks_ok;

  assign lock_raw = {iodelay_rdy_in, dci_locked_in, pll_locked_in};

  nf10_upb_sync_2ff #(
    .WIDTH (3)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (lock_raw),
    .q_o   (lock_s)
  );

  assign locks_ok = lock_s[0]
                  & (lock_s[1] | (USE_DCI == 0))
                  & (lock_s[2] | (USE_IODELAY_CONTROL == 0));

  seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [N_STAGES-1:0] stage_q, stage_d;
  logic                ready_q, ready_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
    end
  end

  // NOTE: every signal driven here gets a hold-value default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    ready_d = ready_q;

    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d   = '0;
        idx_d   = '0;
        stage_d = '0;
        ready_d = 1'b0;
        if (locks_ok) state_d = STABLE;
      end

      STABLE: begin
        if (!locks_ok) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RELEASE: begin
        // Lock loss takes priority over a release due on the same edge.
        if (!locks_ok) begin
          state_d = FAULT;
          cnt_d   = '0;
          stage_d = '0;
          ready_d = 1'b0;
        end else if (cnt_q == DELAY_LAST) begin
          stage_d[idx_q] = 1'b1;
          cnt_d          = '0;
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RUN: begin
        if (!locks_ok) begin
          state_d = FAULT;
          stage_d = '0;
          ready_d = 1'b0;
        end
      end

      FAULT: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
        idx_d   = '0;
        stage_d = '0;
        ready_d = 1'b0;
      end

      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
        idx_d   = '0;
        stage_d = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign stage_reset_n_out = stage_q;
  assign ready_out         = ready_q;

`ifdef NF10_UPB_RESET_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q;
  logic                  fault_entry;

  // FAULT never loops on itself, so a FAULT next-state is always a fresh entry.
  assign fault_entry = (state_d == FAULT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      loss_cnt_q <= '0;
    end else if (fault_entry && (loss_cnt_q != {LOSS_CNT_W{1'b1}})) begin
      loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
    end
  end

  assign lock_loss_count_out = loss_cnt_q;
`else
  assign lock_loss_count_out = '0;
`endif

endmodule
